// File: rtl/score_tracker_if.sv
// Score-path bundle between the line-clear producer and the score/BCD display consumer.
interface score_tracker_if;
    logic       game_start;
    logic       clear_valid;
    logic [2:0] clear_count;
    logic       clear_ready;
    logic [7:0] score;
    logic [3:0] bcd_hundreds;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       bcd_done;

    modport master (
        output game_start, clear_valid, clear_count,
        input  clear_ready, score, bcd_hundreds, bcd_tens, bcd_ones, bcd_done
    );

    modport slave (
        input  game_start, clear_valid, clear_count,
        output clear_ready, score, bcd_hundreds, bcd_tens, bcd_ones, bcd_done
    );
endinterface

// File: rtl/score_tracker.sv
// Saturating score accumulator with sequential double-dabble BCD split; score updates on the accept edge, BCD 8 edges later.
// Backpressure: clear_ready is low for the 8-cycle conversion; a held event is taken once it returns high.
module score_tracker #(
    parameter logic [7:0] PTS1      = 8'd1,
    parameter logic [7:0] PTS2      = 8'd3,
    parameter logic [7:0] PTS3      = 8'd5,
    parameter logic [7:0] PTS4      = 8'd8,
    parameter logic [7:0] MAX_SCORE = 8'd255
) (
    input  logic           clk,
    input  logic           rst,
    score_tracker_if.slave bus
);

    typedef enum logic {IDLE, CONV} state_t;

    state_t      state, state_nxt;
    logic [7:0]  score_q;
    logic [7:0]  pts;
    logic        legal;
    logic [8:0]  sum;
    logic [7:0]  score_new;
    logic        start_conv;
    logic        last_step;
    logic [2:0]  iter;
    logic [19:0] sr;
    logic [19:0] adj;
    logic [19:0] step_sr;
    logic [3:0]  hund_q, tens_q, ones_q;
    logic        done_q;

    always_comb begin
        pts   = 8'd0;
        legal = 1'b1;
        case (bus.clear_count)
            3'd1:    pts = PTS1;
            3'd2:    pts = PTS2;
            3'd3:    pts = PTS3;
            3'd4:    pts = PTS4;
            default: legal = 1'b0;
        endcase
    end

    // Nine-bit sum so an add near the ceiling clamps instead of wrapping.
    assign sum        = {1'b0, score_q} + {1'b0, pts};
    assign score_new  = (sum > {1'b0, MAX_SCORE}) ? MAX_SCORE : sum[7:0];
    assign start_conv = bus.clear_valid && (state == IDLE) && legal && !bus.game_start;
    assign last_step  = (state == CONV) && (iter == 3'd7);

    // Shift register layout: [19:16] hundreds, [15:12] tens, [11:8] ones, [7:0] binary remainder.
    always_comb begin
        adj = sr;
        for (int i = 0; i < 3; i++) begin
            if (sr[8 + 4*i +: 4] >= 4'd5)
                adj[8 + 4*i +: 4] = sr[8 + 4*i +: 4] + 4'd3;
        end
    end
    assign step_sr = adj << 1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.game_start) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_conv) state_nxt = CONV;
                CONV:    if (iter == 3'd7) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score_q <= 8'd0;
            sr      <= 20'd0;
            iter    <= 3'd0;
            hund_q  <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            done_q  <= 1'b0;
        end else if (bus.game_start) begin
            score_q <= 8'd0;
            sr      <= 20'd0;
            iter    <= 3'd0;
            hund_q  <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= last_step;
            if (start_conv) begin
                score_q <= score_new;
                sr      <= {12'd0, score_new};
                iter    <= 3'd0;
            end else if (state == CONV) begin
                sr   <= step_sr;
                iter <= iter + 3'd1;
                if (iter == 3'd7) begin
                    hund_q <= step_sr[19:16];
                    tens_q <= step_sr[15:12];
                    ones_q <= step_sr[11:8];
                end
            end
        end
    end

    assign bus.clear_ready  = (state == IDLE);
    assign bus.score        = score_q;
    assign bus.bcd_hundreds = hund_q;
    assign bus.bcd_tens     = tens_q;
    assign bus.bcd_ones     = ones_q;
    assign bus.bcd_done     = done_q;

endmodule

// File: tb/tb_score_tracker.sv
// Directed-vector bench for score_tracker with hand-computed expectations.
module tb_score_tracker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    score_tracker_if bus();

    score_tracker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int model       = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int pts_of(input int c);
        case (c)
            1:       return 1;
            2:       return 3;
            3:       return 5;
            4:       return 8;
            default: return 0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int cnt);
        int w;
        w = 0;
        while (bus.clear_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        if (w >= 20) check("ready_timeout", 0, 1);
        bus.clear_valid = 1'b1;
        bus.clear_count = cnt[2:0];
        tick();
        bus.clear_valid = 1'b0;
        if (pts_of(cnt) != 0)
            model = (model + pts_of(cnt) > 255) ? 255 : model + pts_of(cnt);
    endtask

    task automatic watch(input int n, output int first, output int pulses, output int low);
        first  = 0;
        pulses = 0;
        low    = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (!bus.clear_ready) low++;
            if (bus.bcd_done) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
    endtask

    task automatic preload(input int target);
        int d, f, p, l;
        while (model < target) begin
            d = target - model;
            send(d >= 8 ? 4 : d >= 5 ? 3 : d >= 3 ? 2 : 1);
            watch(12, f, p, l);
        end
        check("preload_score", bus.score, target);
    endtask

    task automatic check_bcd(input string tag, input int h, input int t, input int o);
        check({tag, "_hund"}, bus.bcd_hundreds, h);
        check({tag, "_tens"}, bus.bcd_tens, t);
        check({tag, "_ones"}, bus.bcd_ones, o);
    endtask

    initial begin
        int f, p, l;
        int s0, s8, s9, r8, d8;

        bus.game_start  = 1'b0;
        bus.clear_valid = 1'b0;
        bus.clear_count = 3'd0;

        // Reset and idle
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_score", bus.score, 0);
        check_bcd("rst", 0, 0, 0);
        check("rst_ready", bus.clear_ready, 1);
        check("rst_done", bus.bcd_done, 0);
        rst = 1'b1;
        watch(20, f, p, l);
        check("idle_done_pulses", p, 0);
        check("idle_ready_low", l, 0);

        // Single 4-line event from zero
        send(4);
        check("single_score", bus.score, 8);
        check("single_ready_busy", bus.clear_ready, 0);
        watch(12, f, p, l);
        check("single_done_cycle", f, 8);
        check("single_done_pulses", p, 1);
        check("single_ready_low", l, 7);
        check_bcd("single", 0, 0, 8);

        // Illegal counts are consumed without effect
        send(0);
        check("illegal0_score", bus.score, 8);
        check("illegal0_ready", bus.clear_ready, 1);
        watch(12, f, p, l);
        check("illegal0_done", p, 0);
        send(5);
        check("illegal5_score", bus.score, 8);
        check("illegal5_ready", bus.clear_ready, 1);
        watch(12, f, p, l);
        check("illegal5_done", p, 0);
        check_bcd("illegal", 0, 0, 8);

        // Digit carry 97 + 3 = 100
        preload(97);
        check_bcd("pre97", 0, 9, 7);
        send(2);
        check("carry_score", bus.score, 100);
        watch(12, f, p, l);
        check("carry_done_cycle", f, 8);
        check_bcd("carry", 1, 0, 0);

        // clear_valid held through a conversion: one add per ready window
        bus.clear_valid = 1'b1;
        bus.clear_count = 3'd1;
        s0 = 0; s8 = 0; s9 = 0; r8 = 0; d8 = 0;
        for (int k = 0; k <= 9; k++) begin
            tick();
            if (k == 0) s0 = bus.score;
            if (k == 8) begin
                s8 = bus.score;
                r8 = bus.clear_ready;
                d8 = bus.bcd_done;
            end
            if (k == 9) s9 = bus.score;
        end
        bus.clear_valid = 1'b0;
        model = model + 2;
        check("hold_first_add", s0, 101);
        check("hold_no_add_busy", s8, 101);
        check("hold_ready_again", r8, 1);
        check("hold_first_done", d8, 1);
        check("hold_second_add", s9, 102);
        watch(12, f, p, l);
        check("hold_second_done_cycle", f, 8);
        check("hold_second_pulses", p, 1);
        check_bcd("hold", 1, 0, 2);

        // Saturation
        preload(250);
        send(4);
        check("sat_score", bus.score, 255);
        watch(12, f, p, l);
        check("sat_done_pulses", p, 1);
        check_bcd("sat", 2, 5, 5);
        send(1);
        check("sat_hold_score", bus.score, 255);
        watch(12, f, p, l);
        check("sat_hold_done_pulses", p, 1);
        check_bcd("sat_hold", 2, 5, 5);

        // game_start four cycles into a conversion
        send(1);
        repeat (4) tick();
        bus.game_start  = 1'b1;
        bus.clear_valid = 1'b1;
        bus.clear_count = 3'd4;
        tick();
        bus.game_start  = 1'b0;
        bus.clear_valid = 1'b0;
        model = 0;
        check("gs_score", bus.score, 0);
        check_bcd("gs", 0, 0, 0);
        check("gs_done", bus.bcd_done, 0);
        check("gs_ready", bus.clear_ready, 1);
        // game_start in idle drops a simultaneous event
        bus.game_start  = 1'b1;
        bus.clear_valid = 1'b1;
        bus.clear_count = 3'd4;
        tick();
        bus.game_start  = 1'b0;
        bus.clear_valid = 1'b0;
        check("gs_drop_score", bus.score, 0);
        check("gs_drop_ready", bus.clear_ready, 1);
        watch(12, f, p, l);
        check("gs_no_done", p, 0);
        check_bcd("gs_after", 0, 0, 0);

        // Asynchronous reset mid-conversion
        send(4);
        check("arst_pre_score", bus.score, 8);
        repeat (3) tick();
        #2 rst = 1'b0;
        #1;
        check("arst_score", bus.score, 0);
        check("arst_ready", bus.clear_ready, 1);
        tick();
        rst = 1'b1;
        model = 0;
        watch(12, f, p, l);
        check("arst_no_done", p, 0);
        check_bcd("arst", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
